// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with IDLE/BUSY/GAP grant sequencing and a muxed shared bus.
// Optional hold-timeout feature enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 15,
    localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [OW-1:0]  owner,
    output logic [W-1:0]   bus,
    output logic           timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t        state, next_state;
    logic [N-1:0]  next_gnt;
    logic [OW-1:0] next_owner, last_owner, next_last;
    logic [OW-1:0] winner, cand;
    logic          found;
    logic          release_now;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] hold_cnt, next_cnt;
    logic          next_timeout;
`endif

    // Round-robin search starts one past the previous owner and wraps.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N; i++) begin
            cand = OW'((int'(last_owner) + i) % N);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign release_now = done[owner] | ~req[owner];

    always_comb begin
        next_state = state;
        next_gnt   = gnt;
        next_owner = owner;
        next_last  = last_owner;
`ifdef BUS_ARBITER_TIMEOUT_EN
        next_cnt     = hold_cnt;
        next_timeout = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    next_state       = BUSY;
                    next_gnt         = '0;
                    next_gnt[winner] = 1'b1;
                    next_owner       = winner;
                    next_last        = winner;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    next_cnt = CW'(1);
`endif
                end
            end
            BUSY: begin
                // A real release wins over the hold limit, so no timeout pulse then.
                if (release_now) begin
                    next_state = GAP;
                    next_gnt   = '0;
                    next_owner = '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    next_cnt = '0;
`endif
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (hold_cnt == CW'(MAX_HOLD)) begin
                    next_state   = GAP;
                    next_gnt     = '0;
                    next_owner   = '0;
                    next_cnt     = '0;
                    next_timeout = 1'b1;
                end else begin
                    next_cnt = hold_cnt + CW'(1);
                end
`endif
            end
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= OW'(N - 1);
        end else begin
            state      <= next_state;
            gnt        <= next_gnt;
            owner      <= next_owner;
            last_owner <= next_last;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= next_cnt;
            timeout  <= next_timeout;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign gnt_valid = |gnt;
    assign bus       = gnt_valid ? din[owner*W +: W] : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (N=4, W=8, MAX_HOLD=15).
// Timeout expectations follow BUS_ARBITER_TIMEOUT_EN when it is defined globally.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        gnt_valid;
    logic [1:0]  owner;
    logic [7:0]  bus;
    logic        timeout;

    int checks_total;
    int checks_passed;
    logic tout_seen;

    bus_arbiter #(.N(4), .W(8), .MAX_HOLD(15)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .din(din),
        .gnt(gnt),
        .gnt_valid(gnt_valid),
        .owner(owner),
        .bus(bus),
        .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive inputs, then advance one clock and settle 1 time unit past the edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkGrant(input string tag, input logic [3:0] g, input logic [1:0] o, input logic [7:0] b);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'(g));
        checkOutput({tag, "_own"}, 32'(owner), 32'(o));
        checkOutput({tag, "_bus"}, 32'(bus), 32'(b));
        checkOutput({tag, "_vld"}, 32'(gnt_valid), 32'(g != 4'b0));
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        tout_seen     = 1'b0;
        rst  = 1'b1;
        req  = '0;
        done = '0;
        din  = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        checkGrant("rst", 4'b0000, 2'd0, 8'h00);
        checkOutput("rst_tout", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester: grant, release, one GAP, one IDLE, re-grant.
        applyStimulus(4'b0001, 4'b0000);
        checkGrant("single", 4'b0001, 2'd0, 8'h11);
        applyStimulus(4'b0001, 4'b0001);
        checkGrant("gap", 4'b0000, 2'd0, 8'h00);
        applyStimulus(4'b0001, 4'b0000);
        checkGrant("idle", 4'b0000, 2'd0, 8'h00);
        applyStimulus(4'b0001, 4'b0000);
        checkGrant("regrant", 4'b0001, 2'd0, 8'h11);
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Fresh reset so requester 0 leads the all-request rotation.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            applyStimulus(4'b1111, 4'b1111);
            if (k % 3 == 0) checkOutput("rr_gnt", 32'(gnt), 32'(4'b0001 << ((k / 3) % 4)));
            else            checkOutput("rr_gap", 32'(gnt), 32'd0);
        end
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Wrap-around from owner 2 with req=1010, and non-owner done ignored.
        applyStimulus(4'b0100, 4'b0000);
        checkGrant("own2", 4'b0100, 2'd2, 8'h33);
        applyStimulus(4'b1010, 4'b0000);
        checkGrant("drop2", 4'b0000, 2'd0, 8'h00);
        applyStimulus(4'b1010, 4'b0000);
        applyStimulus(4'b1010, 4'b0000);
        checkGrant("own3", 4'b1000, 2'd3, 8'h44);
        applyStimulus(4'b1010, 4'b1000);
        checkGrant("rel3", 4'b0000, 2'd0, 8'h00);
        applyStimulus(4'b1010, 4'b1000);
        applyStimulus(4'b1010, 4'b1000);
        checkGrant("own1", 4'b0010, 2'd1, 8'h22);
        applyStimulus(4'b1010, 4'b1000);
        checkGrant("ign3", 4'b0010, 2'd1, 8'h22);
        applyStimulus(4'b1010, 4'b0101);
        checkGrant("ign02", 4'b0010, 2'd1, 8'h22);
        applyStimulus(4'b1010, 4'b0010);
        checkGrant("rel1", 4'b0000, 2'd0, 8'h00);
        applyStimulus(4'b0000, 4'b0000);

        // Hold behaviour with requester 1 never signalling done.
        applyStimulus(4'b0010, 4'b0000);
        checkGrant("hold", 4'b0010, 2'd1, 8'h22);
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 14; k++) begin
            applyStimulus(4'b0010, 4'b0000);
            tout_seen = tout_seen | timeout | (gnt != 4'b0010);
        end
        checkOutput("hold14", 32'(tout_seen), 32'd0);
        applyStimulus(4'b0010, 4'b0000);
        checkGrant("tdrop", 4'b0000, 2'd0, 8'h00);
        checkOutput("tpulse", 32'(timeout), 32'd1);
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("tpulse_end", 32'(timeout), 32'd0);
        applyStimulus(4'b0010, 4'b0000);
        checkGrant("tregrant", 4'b0010, 2'd1, 8'h22);
        for (int k = 0; k < 14; k++) applyStimulus(4'b0010, 4'b0000);
        applyStimulus(4'b0010, 4'b0010);
        checkGrant("donelim", 4'b0000, 2'd0, 8'h00);
        checkOutput("donelim_tout", 32'(timeout), 32'd0);
`else
        for (int k = 0; k < 120; k++) begin
            applyStimulus(4'b0010, 4'b0000);
            tout_seen = tout_seen | timeout;
            if (k % 20 == 19) checkOutput("hold_gnt", 32'(gnt), 32'(4'b0010));
        end
        checkOutput("hold_tout", 32'(tout_seen), 32'd0);
        applyStimulus(4'b0000, 4'b0000);
        checkGrant("hold_rel", 4'b0000, 2'd0, 8'h00);
`endif
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Asynchronous reset between clock edges while owner 2 holds the bus.
        applyStimulus(4'b0100, 4'b0000);
        checkGrant("pre_rst", 4'b0100, 2'd2, 8'h33);
        #2;
        rst = 1'b1;
        #1;
        checkGrant("async_rst", 4'b0000, 2'd0, 8'h00);
        #2;
        rst = 1'b0;
        applyStimulus(4'b1001, 4'b0000);
        checkGrant("post_rst", 4'b0001, 2'd0, 8'h11);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001: Parameter N, default 4, number of requesters (2..8) sharing the bus SHALL be supported.
REQ-002: Parameter W, default 8, data width of each requester and of the shared bus.
REQ-003: Parameter MAX_HOLD, default 15, maximum consecutive BUSY cycles for one owner (timeout build only).
REQ-004: clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: req  input  N  request per requester; held high until granted and done.
REQ-007: done  input  N  release strobe from the current owner.
REQ-008: din  input  N*W  packed per-requester data, requester k at bits [k*W+W-1:k*W].
REQ-009: gnt  output  N  registered grant, one-hot or zero.
REQ-010: gnt_valid  output  1  high when any gnt bit is high.
REQ-011: owner  output  clog2(N)  index of the granted requester; 0 when gnt_valid is low.
REQ-012: bus  output  W  shared bus: din slice of owner when gnt_valid is high, else all zero (combinational).
REQ-013: timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-014: The FSM SHALL have exactly three states: IDLE, BUSY and GAP.
REQ-015: IDLE: if any req bit is high at posedge t, the block SHALL select a winner, assert its gnt bit from t+1, and enter BUSY; otherwise it stays in IDLE.
REQ-016: Winner selection SHALL be round-robin: search from index (last_owner+1) mod N upward with wrap-around; first asserted req wins.
REQ-017: last_owner SHALL update to the winner when a grant is issued.
REQ-018: BUSY: gnt SHALL stay constant until done[owner]=1 or req[owner]=0 at a posedge; the block then enters GAP with gnt cleared from the next cycle.
REQ-019: done or req from non-owners SHALL be ignored in BUSY.
REQ-020: GAP SHALL last exactly one cycle with gnt=0 and bus=0 (turnaround), then go to IDLE; requests in GAP are not arbitrated until IDLE.
REQ-021: Minimum grant-to-grant spacing SHALL therefore be 3 cycles (BUSY>=1, GAP=1, IDLE=1).
REQ-022: A single continuously requesting requester SHALL be re-granted after each GAP/IDLE pair.
REQ-023: gnt SHALL never have more than one bit set.

Reset
REQ-024: On rst high, immediately and asynchronously: state=IDLE, gnt=0, gnt_valid=0, owner=0, timeout=0, hold counter=0, last_owner=N-1 (requester 0 has first priority).
REQ-025: Reset asserted mid-grant SHALL drop gnt and bus to zero without waiting for a clock edge.
REQ-026: After rst deasserts, the first posedge SHALL behave as IDLE with the reset priority.

Configuration
REQ-027: Macro BUS_ARBITER_TIMEOUT_EN SHALL control the hold-timeout feature.
REQ-028: Defined: a counter SHALL count BUSY cycles from 1; in the cycle in which it equals MAX_HOLD without release, the block SHALL enter GAP and pulse timeout for one cycle coincident with gnt dropping.
REQ-029: Defined: if done[owner] and the limit occur in the same cycle, the release SHALL be normal and timeout SHALL stay low.
REQ-030: Undefined: no counter SHALL be built, timeout SHALL be tied 0, and grants SHALL be unbounded.

Verification
REQ-031: Reset then req=4'b0001 at t -> gnt=0001, owner=0, bus=din[7:0] at t+1; done[0] -> gnt=0 next cycle, GAP 1 cycle.
REQ-032: req=4'b1111 held, done pulsed each BUSY cycle -> grant order 0,1,2,3,0 with 3-cycle spacing.
REQ-033: Owner 2 granted, req=4'b1010 -> next winner 3, then 1 (wrap-around).
REQ-034: Timeout build, MAX_HOLD=15, req[1] held, no done -> gnt drops after 15 BUSY cycles, timeout=1 for exactly 1 cycle; non-timeout build -> grant held 100+ cycles, timeout=0.
REQ-035: rst pulsed mid-BUSY (not on a clock edge) -> gnt, bus, gnt_valid become 0 immediately; after release, req=4'b1001 -> requester 0 wins.
REQ-036: done[3] while owner=1 -> ignored, gnt unchanged; done[1] together with limit reached -> timeout stays 0.
